// File: rtl/ddr_tx.sv
// ddr_tx: HDR-DDR word transmitter serialising COMMAND/DATA/CRC words onto SDA on both SCL edges.
module ddr_tx #(
  parameter logic [4:0] CRC_INIT = 5'h1F,
  parameter logic       SDA_IDLE = 1'b1
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_tx_en,
  input  logic [1:0]  i_tx_mode,
  input  logic [15:0] i_regf_tx_data,
  input  logic        i_scl_pos_edge,
  input  logic        i_scl_neg_edge,
  output logic        o_sda,
  output logic        o_tx_mode_done,
  output logic        o_tx_busy,
  output logic [4:0]  o_crc_value
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [19:0] sh_q, sh_d, word;
  logic [4:0]  idx_q, idx_d, crc_q, crc_d, crc_upd, last;
  logic        sda_q, sda_d, done_q, done_d, busy_q, busy_d, is_crc_q, is_crc_d;
  logic        edge_ev, p1, p0, load;
  logic [15:0] d_rev;
  for (genvar g = 0; g < 16; g++) begin : g_rev
    assign d_rev[g] = i_regf_tx_data[15-g];
  end
  assign edge_ev = i_scl_pos_edge | i_scl_neg_edge;
  assign p1 = ^(i_regf_tx_data & 16'hAAAA);
  assign p0 = ~^(i_regf_tx_data & 16'h5555);
  assign last = is_crc_q ? 5'd10 : 5'd19;
  assign load = i_tx_en && (i_tx_mode != 2'd3);
  // Words are stored LSB-first so bit 0 of the shift register is the next bit on the wire.
  always_comb begin
    word = (i_tx_mode == 2'd2) ? {9'b0, crc_q[0], crc_q[1], crc_q[2], crc_q[3], crc_q[4], 4'b0011, 2'b10}
         : (i_tx_mode == 2'd1) ? {p0, p1, d_rev, 2'b01}
         : {p0, p1, d_rev, 2'b10};
    crc_upd = crc_q;
    for (int i = 15; i >= 0; i--)
      crc_upd = {crc_upd[3:0], 1'b0} ^ ((crc_upd[4] ^ i_regf_tx_data[i]) ? 5'b00101 : 5'b00000);
  end
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    sda_d    = sda_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    crc_d    = crc_q;
    is_crc_d = is_crc_q;
    case (state_q)
      IDLE: begin
        sda_d = load ? word[0] : SDA_IDLE;
        if (load) begin
          state_d  = SHIFT;
          sh_d     = word;
          idx_d    = 5'd0;
          busy_d   = 1'b1;
          is_crc_d = i_tx_mode == 2'd2;
          crc_d    = (i_tx_mode == 2'd0) ? CRC_INIT : (i_tx_mode == 2'd1) ? crc_upd : crc_q;
        end
      end
      SHIFT: begin
        if (!i_tx_en) begin
          state_d = IDLE;
          sda_d   = SDA_IDLE;
          busy_d  = 1'b0;
          idx_d   = 5'd0;
        end else if (edge_ev && idx_q == last) begin
          state_d = GAP;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (edge_ev) begin
          idx_d = idx_q + 5'd1;
          sh_d  = sh_q >> 1;
          sda_d = sh_q[1];
        end
      end
      default: begin
        state_d = IDLE;
        sda_d   = SDA_IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      idx_q    <= '0;
      sda_q    <= SDA_IDLE;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      crc_q    <= CRC_INIT;
      is_crc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      sda_q    <= sda_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      crc_q    <= crc_d;
      is_crc_q <= is_crc_d;
    end
  end
  assign o_sda          = sda_q;
  assign o_tx_mode_done = done_q;
  assign o_tx_busy      = busy_q;
  assign o_crc_value    = crc_q;
endmodule

// File: tb/tb_ddr_tx.sv
// tb_ddr_tx: table-driven scoreboard bench for ddr_tx word serialisation, parity, CRC5 and abort.
module tb_ddr_tx;
  logic clk = 0, rst_n = 0, en = 0, pos = 0, neg = 0;
  logic [1:0] mode = 0;
  logic [15:0] data = 0;
  logic sda, done, busy;
  logic [4:0] crc;
  always #5 clk = ~clk;
  ddr_tx dut (
    .i_sys_clk(clk), .i_sys_rst(rst_n), .i_tx_en(en), .i_tx_mode(mode),
    .i_regf_tx_data(data), .i_scl_pos_edge(pos), .i_scl_neg_edge(neg),
    .o_sda(sda), .o_tx_mode_done(done), .o_tx_busy(busy), .o_crc_value(crc)
  );
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    int          abort_at;
    logic [4:0]  crc_exp;
    bit          crc_known;
  } vec_t;
  vec_t vecs[9];
  bit exp_q[$];
  logic [4:0] m_crc = 5'h1F;
  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] crc5(input logic [4:0] c, input logic [15:0] d);
    logic [4:0] r;
    logic fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[4] ^ d[i];
      r = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'b00101;
    end
    return r;
  endfunction
  task automatic push_word(input logic [1:0] md, input logic [15:0] d);
    bit p1, p0;
    p1 = 0;
    p0 = 1;
    if (md == 2'd1) begin exp_q.push_back(1); exp_q.push_back(0); end
    else begin exp_q.push_back(0); exp_q.push_back(1); end
    if (md == 2'd2) begin
      exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
      for (int i = 4; i >= 0; i--) exp_q.push_back(m_crc[i]);
    end else begin
      for (int i = 15; i >= 0; i--) exp_q.push_back(d[i]);
      for (int i = 0; i < 16; i++)
        if (i % 2 == 1) p1 = p1 ^ d[i];
        else p0 = p0 ^ d[i];
      exp_q.push_back(p1);
      exp_q.push_back(p0);
    end
  endtask
  task automatic send(input vec_t v);
    int n;
    bit b;
    n = (v.mode == 2'd2) ? 11 : 20;
    push_word(v.mode, v.data);
    if (v.mode == 2'd0) m_crc = 5'h1F;
    else if (v.mode == 2'd1) m_crc = crc5(m_crc, v.data);
    en = 1; mode = v.mode; data = v.data;
    tick;
    mode = 2'($urandom); data = 16'($urandom);
    chk("busy_load", busy, 1);
    chk("crc_load", crc, v.crc_known ? v.crc_exp : m_crc);
    for (int k = 0; k < n; k++) begin
      b = exp_q.pop_front();
      chk("sda_bit", sda, b);
      chk("done_early", done, 0);
      if (k == v.abort_at) begin
        en = 0;
        tick;
        chk("abort_sda", sda, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_crc", crc, m_crc);
        exp_q.delete();
        return;
      end
      pos = (k % 3 != 1);
      neg = (k % 3 != 0);
      tick;
      pos = 0; neg = 0;
      if (k == n - 1) begin
        chk("done_pulse", done, 1);
        chk("sda_last_hold", sda, b);
      end else repeat (3) tick;
    end
    tick;
    chk("done_single", done, 0);
    chk("gap_sda", sda, 1);
    chk("gap_busy", busy, 0);
    en = 0;
  endtask
  initial begin
    vecs[0] = '{2'd0, 16'h0000, -1, 5'h1F, 1};
    vecs[1] = '{2'd1, 16'hA5A5, -1, 5'h00, 0};
    vecs[2] = '{2'd0, 16'h0000, -1, 5'h1F, 1};
    vecs[3] = '{2'd1, 16'h0000, -1, 5'h01, 1};
    vecs[4] = '{2'd2, 16'h0000, -1, 5'h01, 1};
    vecs[5] = '{2'd1, 16'h1234,  7, 5'h00, 0};
    vecs[6] = '{2'd0, 16'hBEEF, -1, 5'h1F, 1};
    vecs[7] = '{2'd1, 16'hFFFF, -1, 5'h00, 0};
    vecs[8] = '{2'd2, 16'h0000, -1, 5'h00, 0};
    for (int c = 0; c < 4; c++) begin
      pos = c[0]; neg = ~c[0];
      tick;
      chk("rst_sda", sda, 1);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_crc", crc, 5'h1F);
    end
    pos = 0; neg = 0;
    rst_n = 1;
    repeat (3) tick;
    chk("idle_sda", sda, 1);
    chk("idle_busy", busy, 0);
    en = 1; mode = 2'd3; data = 16'hFFFF;
    for (int c = 0; c < 4; c++) begin
      pos = 1; neg = c[0];
      tick;
      pos = 0; neg = 0;
      tick;
      chk("mode3_sda", sda, 1);
      chk("mode3_busy", busy, 0);
      chk("mode3_crc", crc, 5'h1F);
    end
    en = 0;
    tick;
    for (int i = 0; i < 9; i++) send(vecs[i]);
    en = 1; mode = 2'd1; data = 16'hFFFF;
    tick;
    pos = 1;
    tick;
    pos = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_sda", sda, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_crc", crc, 5'h1F);
    en = 0;
    tick;
    rst_n = 1;
    tick;
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ddr_tx.md
Name: ddr_tx

Overview:
- HDR-DDR word transmitter. It is the counterpart of the RX block and drives SDA with command, data and CRC words on both SCL edges.
- It is driven by ddr_mode (`o_tx_en`/`o_tx_mode` → `i_tx_en`/`i_tx_mode`, `i_tx_mode_done` ← `o_tx_mode_done`) and paced by scl_generation edge strobes.
- It computes the per-word parity bits and keeps a running CRC5 over data payloads.

Parameters:
- CRC_INIT, 5'h1F, CRC5 seed, loaded when a COMMAND word is loaded.
- SDA_IDLE, 1'b1, level driven on `o_sda` when not transmitting.

Ports:
- `i_sys_clk` in 1: system clock.
- `i_sys_rst` in 1: reset, asynchronous, active-low.
- `i_tx_en` in 1: level; request/continue transmission.
- `i_tx_mode` in 2: word type. 0 = COMMAND, 1 = DATA, 2 = CRC, 3 = reserved.
- `i_regf_tx_data` in 16: payload for COMMAND/DATA words, sampled at load.
- `i_scl_pos_edge` in 1: one-cycle strobe on each SCL rising edge.
- `i_scl_neg_edge` in 1: one-cycle strobe on each SCL falling edge.
- `o_sda` out 1: serial data to the SDA handler.
- `o_tx_mode_done` out 1: one-cycle pulse, word fully sent.
- `o_tx_busy` out 1: high in LOAD/SHIFT.
- `o_crc_value` out 5: current CRC5 register.

Behaviour:
- **Reset** (async, `i_sys_rst`=0):
  - state=IDLE, `o_sda`=SDA_IDLE, `o_tx_mode_done`=0, `o_tx_busy`=0.
  - `o_crc_value`=CRC_INIT, bit index=0.
  - Reset mid-word abandons the word immediately.
- **Edge event:** `i_scl_pos_edge` | `i_scl_neg_edge`. Both high in the same cycle counts as one event.
- **Word formats**, transmitted in order, bit 0 first:
  - COMMAND (20 bits): preamble 0,1; payload D15..D0 (MSB first); P1, P0.
  - DATA (20 bits): preamble 1,0; payload D15..D0; P1, P0.
  - CRC (11 bits): preamble 0,1; token 1,1,0,0; CRC4..CRC0.
- **Parity:**
  - P1 = D15^D13^D11^D9^D7^D5^D3^D1.
  - P0 = D14^D12^D10^D8^D6^D4^D2^D0^1.
- **CRC5:** poly x^5+x^2+1, MSB-first. Per bit: fb=crc[4]^d; crc={crc[3:0],1'b0}^(fb?5'b00101:0).
  - A COMMAND load sets crc=CRC_INIT.
  - A DATA load updates crc over all 16 payload bits, registered at load.
  - Preamble, parity and CRC words never update crc.
- **FSM IDLE → LOAD → SHIFT → GAP → IDLE:**
  - **IDLE:** if `i_tx_en`=1 and mode∈{0,1,2}, latch the word into the shift register. `o_sda`=bit 0 on the next clock; go SHIFT, busy=1. Mode 3 is ignored (stay IDLE, `o_sda`=SDA_IDLE).
  - **SHIFT:** on each edge event, bit index increments and `o_sda`=next bit on the following clock. No edge means `o_sda` holds.
  - **SHIFT, last bit:** on the edge event consuming the last bit (index 19 or 10), register `o_tx_mode_done`=1 and go GAP. `o_sda` holds the last bit.
  - **GAP (1 cycle):** `o_tx_mode_done`=0, `o_sda`=SDA_IDLE, go IDLE. This gives ddr_mode one cycle to update mode and data.
- **Timing:**
  - Load-to-first-bit latency is 1 clock.
  - Last edge to done pulse is 1 clock.
  - Next word's bit 0 is valid 3 clocks after the last edge. SCL edge spacing must be ≥4 sys clocks.
- **Abort:** `i_tx_en`=0 in SHIFT goes to IDLE next clock with `o_sda`=SDA_IDLE, no done pulse, crc unchanged.
- **Ignored inputs:**
  - Edge events in IDLE/GAP are ignored.
  - `i_tx_mode` and `i_regf_tx_data` changes during SHIFT are ignored.

Test Plan:
- **Reset:** reset asserted with strobes toggling → `o_sda`=1, done=0, busy=0, `o_crc_value`=5'h1F; deassert, stays idle.
- **COMMAND 16'h0000** → SDA across 20 edges = 0,1, sixteen 0s, 0,1. Single done pulse 1 clock after the 20th edge; crc=5'h1F.
- **DATA after COMMAND, 16'hA5A5** → 1,0, 1010010110100101, 0,1 (P1=0, P0=1). Done after the 20th edge.
- **COMMAND, then DATA 16'h0000, then CRC** → after the data load `o_crc_value`=5'h01. The CRC word is 0,1,1,1,0,0,0,0,0,0,1 and done follows the 11th edge.
- **Abort:** drop `i_tx_en` after the 7th edge of a DATA word → `o_sda`=1 next clock, no done, busy=0. A new COMMAND then starts from bit 0.
- **Ignored events:** mode 3 with `i_tx_en`=1 → no load, SDA stays 1. Simultaneous pos/neg strobe in SHIFT advances exactly one bit.
